mem_port_arbiter: RTL and testbench

//   Parametrised N-port arbiter sharing one external memory port among pipeline requesters (ICache refill, DCache, future DMA).

---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin N-port arbiter onto one external memory port; define ARB_TIMEOUT_EN to add a WAIT watchdog
module mem_port_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          port_req,
  input  logic [NUM_PORTS-1:0]          port_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0] port_be,
  output logic [DATA_W-1:0]             port_rdata,
  output logic [NUM_PORTS-1:0]          port_done,
  output logic [NUM_PORTS-1:0]          port_stall,
  output logic [NUM_PORTS-1:0]          port_err,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [DATA_W/8-1:0]           mem_be,
  input  logic                          mem_ready,
  input  logic [DATA_W-1:0]             mem_rdata
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int BW = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;
  stateT state;
  logic [PW-1:0] rrPtr, grant, nextGrant, rrNext;
  logic [NUM_PORTS-1:0] hiReq, cand;
  logic selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic [BW-1:0] selBe;
  logic timedOut;
  assign port_stall = port_req & ~port_done;
  assign rrNext = (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] waitCnt;
  assign timedOut = (waitCnt == CW'(TIMEOUT_CYC - 1));
`else
  assign timedOut = 1'b0;
  assign port_err = '0;
`endif
  // Pick the first requester at or above rrPtr, else wrap to the lowest requester, and mux its payload
  always_comb begin
    hiReq = '0;
    for (int i = 0; i < NUM_PORTS; i++) hiReq[i] = port_req[i] && (PW'(i) >= rrPtr);
    cand = (|hiReq) ? hiReq : port_req;
    nextGrant = '0;
    selWe = 1'b0;
    selAddr = '0;
    selWdata = '0;
    selBe = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        nextGrant = PW'(i);
        selWe = port_we[i];
        selAddr = port_addr[i*ADDR_W +: ADDR_W];
        selWdata = port_wdata[i*DATA_W +: DATA_W];
        selBe = port_be[i*BW +: BW];
      end
    end
  end
  // IDLE -> WAIT -> RESP -> IDLE: one transaction in flight, done/err pulse during RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rrPtr <= '0;
      grant <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
      port_rdata <= '0;
      port_done <= '0;
`ifdef ARB_TIMEOUT_EN
      port_err <= '0;
      waitCnt <= '0;
`endif
    end else begin
      port_done <= '0;
`ifdef ARB_TIMEOUT_EN
      port_err <= '0;
`endif
      case (state)
        IDLE: begin
          if (|port_req) begin
            grant <= nextGrant;
            mem_req <= 1'b1;
            mem_we <= selWe;
            mem_addr <= selAddr;
            mem_wdata <= selWdata;
            mem_be <= selBe;
            state <= WAIT;
`ifdef ARB_TIMEOUT_EN
            waitCnt <= '0;
`endif
          end
        end
        WAIT: begin
          if (mem_ready || timedOut) begin
            mem_req <= 1'b0;
            port_done[grant] <= 1'b1;
            port_rdata <= mem_ready ? (mem_we ? port_rdata : mem_rdata) : '1;
            rrPtr <= rrNext;
            state <= RESP;
          end
`ifdef ARB_TIMEOUT_EN
          port_err[grant] <= timedOut & ~mem_ready;
          waitCnt <= waitCnt + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk, rst;
  logic [NP-1:0] port_req, port_we, port_done, port_stall, port_err;
  logic [NP*AW-1:0] port_addr;
  logic [NP*DW-1:0] port_wdata;
  logic [NP*BW-1:0] port_be;
  logic [DW-1:0] port_rdata, mem_wdata, mem_rdata;
  logic mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_be(port_be),
    .port_rdata(port_rdata), .port_done(port_done), .port_stall(port_stall), .port_err(port_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nTotal, nPass, lat, age;
  bit hang, stray, autoDrop, useData, ok;
  logic [DW-1:0] nextData;
  int dutLog[$];

  bit mBusy, mResp, mMemReq, mWe;
  int mRr, mOwner, mWait;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWdata, mRdata;
  logic [BW-1:0] mBe;
  logic [NP-1:0] mDone, mErr;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic setPort(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
    port_we[i] = we;
    port_addr[i*AW +: AW] = a;
    port_wdata[i*DW +: DW] = d;
    port_be[i*BW +: BW] = b;
  endtask

  // One bus transaction at a time, served round-robin from the port after the last one served
  task automatic modelStep();
    bit fin, tmo;
    fin = 0;
    tmo = 0;
    mDone = '0;
    mErr = '0;
    if (rst) begin
      mBusy = 0; mResp = 0; mRr = 0; mMemReq = 0; mWe = 0;
      mAddr = '0; mWdata = '0; mBe = '0; mRdata = '0;
    end else if (mResp) mResp = 0;
    else if (mBusy) begin
      if (mem_ready) fin = 1;
      else if (TO_EN && mWait + 1 == TO) begin fin = 1; tmo = 1; end
      else mWait++;
      if (fin) begin
        mBusy = 0; mResp = 1; mMemReq = 0;
        mDone[mOwner] = 1'b1;
        mErr[mOwner] = tmo;
        if (tmo) mRdata = '1;
        else if (!mWe) mRdata = mem_rdata;
        mRr = (mOwner + 1) % NP;
      end
    end else if (port_req != 0) begin
      for (int k = 0; k < NP; k++) if (port_req[(mRr + k) % NP]) begin mOwner = (mRr + k) % NP; break; end
      mBusy = 1; mWait = 0; mMemReq = 1;
      mWe = port_we[mOwner];
      mAddr = port_addr[mOwner*AW +: AW];
      mWdata = port_wdata[mOwner*DW +: DW];
      mBe = port_be[mOwner*BW +: BW];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    modelStep();
    chk("mem_req", mem_req, mMemReq);
    if (mMemReq) chk("mem_cmd", {mem_we, mem_addr, mem_wdata, mem_be}, {mWe, mAddr, mWdata, mBe});
    chk("port_done", port_done, mDone);
    chk("port_err", port_err, mErr);
    chk("port_rdata", port_rdata, mRdata);
    chk("port_stall", port_stall, port_req & ~mDone);
    for (int i = 0; i < NP; i++) if (port_done[i]) dutLog.push_back(i);
    if (mem_ready) mem_ready = 1'b0;
    else if (mem_req && !rst) begin
      age++;
      if (!hang && age >= lat) begin
        mem_ready = 1'b1;
        mem_rdata = useData ? nextData : $urandom;
      end
    end else begin
      age = 0;
      mem_ready = stray && ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end
    if (autoDrop) port_req = port_req & ~port_done;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic waitIdle(input string nm, input int budget);
    for (int n = 0; n < budget && (port_req != 0 || mem_req); n++) tick();
    chk({nm, "_idle"}, {port_req == 0, mem_req}, 2'b10);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nTotal = 0; nPass = 0; age = 0; lat = 1;
    hang = 0; stray = 0; autoDrop = 1; useData = 0; nextData = '0; ok = 1;
    rst = 1'b1; port_req = '0; port_we = '0; port_addr = '0; port_wdata = '0; port_be = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    tick();
    tick();
    chk("reset_state", {mem_req, mem_we, mem_addr, mem_wdata, mem_be, port_done, port_err, port_rdata}, '0);
    rst = 1'b0;

    // port 0 read, memory answers on the third cycle after mem_req
    setPort(0, 1'b0, 32'h100, '0, 4'hF);
    lat = 4; useData = 1; nextData = 32'h12345678;
    port_req = 3'b001;
    tick();
    chk("t1_grant", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h100});
    tick(); tick(); tick();
    chk("t1_wait", {port_done, port_stall[0]}, {3'b000, 1'b1});
    tick();
    chk("t1_done", {port_done, port_rdata}, {3'b001, 32'h12345678});
    tick();
    chk("t1_after", {port_done, mem_req}, '0);

    // simultaneous requests after reset, then wrap past the top port
    doReset();
    lat = 1; useData = 0;
    dutLog.delete();
    port_req = 3'b011;
    waitIdle("t2a", 40);
    port_req = 3'b101;
    waitIdle("t2b", 40);
    chk("t2_order", {4'(dutLog.size()), 4'(dutLog[0]), 4'(dutLog[1]), 4'(dutLog[2]), 4'(dutLog[3])},
        {4'd4, 4'd0, 4'd1, 4'd2, 4'd0});

    // two ports holding requests alternate
    doReset();
    autoDrop = 0;
    dutLog.delete();
    port_req = 3'b011;
    for (int n = 0; n < 60 && dutLog.size() < 4; n++) tick();
    chk("t3_order", {4'(dutLog.size()), 4'(dutLog[0]), 4'(dutLog[1]), 4'(dutLog[2]), 4'(dutLog[3])},
        {4'd4, 4'd0, 4'd1, 4'd0, 4'd1});
    port_req = '0;
    autoDrop = 1;
    waitIdle("t3", 40);

    // a write leaves the last read data in place
    setPort(2, 1'b0, 32'h40, '0, 4'hF);
    useData = 1; nextData = 32'hCAFEF00D;
    port_req = 3'b100;
    waitIdle("t4a", 40);
    chk("t4_read", port_rdata, 32'hCAFEF00D);
    setPort(1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'b0011);
    nextData = 32'hDEADBEEF;
    dutLog.delete();
    port_req = 3'b010;
    tick();
    chk("t4_cmd", {mem_req, mem_we, mem_addr, mem_wdata, mem_be}, {1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'b0011});
    waitIdle("t4b", 40);
    chk("t4_write", {port_rdata, 4'(dutLog.size()), 4'(dutLog[0])}, {32'hCAFEF00D, 4'd1, 4'd1});

    // reset in WAIT drops the transaction and restarts round-robin at port 0
    hang = 1;
    port_req = 3'b010;
    tick(); tick();
    chk("t5_wait", mem_req, 1'b1);
    rst = 1'b1; port_req = '0;
    tick();
    rst = 1'b0;
    chk("t5_reset", {mem_req, mem_we, mem_addr, mem_wdata, mem_be, port_done, port_err, port_rdata}, '0);
    hang = 0; useData = 0;
    dutLog.delete();
    port_req = 3'b101;
    waitIdle("t5", 40);
    chk("t5_order", {4'(dutLog.size()), 4'(dutLog[0]), 4'(dutLog[1])}, {4'd2, 4'd0, 4'd2});

    // memory never answers
    setPort(0, 1'b0, 32'h300, '0, 4'hF);
    hang = 1;
    port_req = 3'b001;
`ifdef ARB_TIMEOUT_EN
    tick();
    chk("t6_req", mem_req, 1'b1);
    tick(); tick(); tick();
    chk("t6_wait", {mem_req, port_done}, {1'b1, 3'b000});
    tick();
    chk("t6_timeout", {mem_req, port_done, port_err, port_rdata}, {1'b0, 3'b001, 3'b001, 32'hFFFFFFFF});
    hang = 0;
    waitIdle("t6", 40);
`else
    repeat (100) begin
      tick();
      if (!(mem_req === 1'b1 && port_stall[0] === 1'b1)) ok = 0;
    end
    chk("t6_no_timeout", ok, 1'b1);
    rst = 1'b1; port_req = '0;
    tick();
    rst = 1'b0;
    hang = 0;
`endif

    // randomized traffic with stray mem_ready, early drops and occasional reset
    stray = 1; autoDrop = 0; useData = 0;
    repeat (3000) begin
      if (!mem_req) lat = $urandom_range(1, 6);
      rst = ($urandom_range(0, 399) == 0);
      tick();
      for (int i = 0; i < NP; i++) begin
        if (port_done[i]) port_req[i] = 1'b0;
        else if (!port_req[i] && $urandom_range(0, 2) == 0) begin
          setPort(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
          port_req[i] = 1'b1;
        end else if (port_req[i] && $urandom_range(0, 99) == 0) port_req[i] = 1'b0;
      end
    end
    rst = 1'b0;
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end
endmodule
